// File: rtl/neo_b1_pkg.sv
// Shared definitions for the B1 sprite line buffer: depth, strobe bit indices, entry type.
package neo_b1_pkg;

    localparam int unsigned LB_DEPTH = 256;

    // WE/CK bit positions
    localparam int unsigned IDX_ODD_A  = 0;
    localparam int unsigned IDX_EVEN_A = 1;
    localparam int unsigned IDX_ODD_B  = 2;
    localparam int unsigned IDX_EVEN_B = 3;

    // {palette[7:0], colour[3:0]}
    typedef logic [11:0] lb_entry_t;

endpackage

// File: rtl/lb_half.sv
// One line-buffer half: 8-bit X counter, entry RAM, write port and read port.
// NEO_B1_LB_CLEAR_EN: a WE on the read side clears the addressed entry.
module lb_half #(
    parameter int unsigned DEPTH = neo_b1_pkg::LB_DEPTH
) (
    input  logic                  CLK_24M,
    input  logic                  RESETP,
    input  logic                  i_load,
    input  logic [7:0]            i_load_addr,
    input  logic                  i_ck_rise,
    input  logic                  i_we_fall,
    input  logic                  i_wr_side,
    input  neo_b1_pkg::lb_entry_t i_wr_data,
    output logic                  o_rd_en,
    output neo_b1_pkg::lb_entry_t o_rd_data,
    output logic [7:0]            o_addr
);
    import neo_b1_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    lb_entry_t     r_mem [DEPTH];
    logic [7:0]    r_addr;
    logic [AW-1:0] w_idx;
    logic          w_wr;
    lb_entry_t     w_wr_data;

    assign w_idx = r_addr[AW-1:0];

`ifdef NEO_B1_LB_CLEAR_EN
    assign w_wr      = i_we_fall;
    assign w_wr_data = i_wr_side ? i_wr_data : '0;
`else
    assign w_wr      = i_we_fall & i_wr_side;
    assign w_wr_data = i_wr_data;
`endif

    // Load has priority over the advance strobe
    always_ff @(posedge CLK_24M or posedge RESETP) begin
        if (RESETP) begin
            r_addr <= 8'h00;
        end else if (i_load) begin
            r_addr <= i_load_addr;
        end else if (i_ck_rise) begin
            r_addr <= r_addr + 8'd1;
        end
    end

    // Buffer RAM is deliberately left without reset
    always_ff @(posedge CLK_24M) begin
        if (w_wr) begin
            r_mem[w_idx] <= w_wr_data;
        end
    end

    // Read and write both see the pre-increment address
    assign o_rd_en   = i_ck_rise & ~i_wr_side;
    assign o_rd_data = r_mem[w_idx];
    assign o_addr    = r_addr;

endmodule

// File: rtl/neo_b1_linebuf.sv
// B1 sprite line buffer: strobe edge detection, four lb_half instances, SPR_OUT and PA mux.
// NEO_B1_LB_CLEAR_EN (in lb_half) enables clear-after-read.
module neo_b1_linebuf #(
    parameter int unsigned LB_DEPTH = neo_b1_pkg::LB_DEPTH
) (
    input  logic        CLK_24M,
    input  logic        RESETP,
    input  logic [23:0] PBUS,
    input  logic        PCK2,
    input  logic        LD1_,
    input  logic        LD2_,
    input  logic [3:0]  WE,
    input  logic [3:0]  CK,
    input  logic        BFLIP,
    input  logic [3:0]  GAD,
    input  logic [3:0]  GBD,
    input  logic [3:0]  FIXD,
    input  logic [3:0]  FIX_PAL,
    input  logic        CHBL,
    output logic [15:0] PA
);
    import neo_b1_pkg::*;

    logic [7:0]  r_pal_in;
    logic [7:0]  r_x_in;
    logic [3:0]  r_gad;
    logic [3:0]  r_gbd;
    logic        r_pck2_c;
    logic        r_pck2_p;
    logic [1:0]  r_ld_c;
    logic [1:0]  r_ld_p;
    logic [3:0]  r_we_c;
    logic [3:0]  r_we_p;
    logic [3:0]  r_ck_c;
    logic [3:0]  r_ck_p;
    logic [1:0]  r_arm;
    logic        r_bflip;
    logic [7:0]  r_pal;
    lb_entry_t   r_spr;
    logic [15:0] r_pa;

    logic        w_armed;
    logic        w_pck2_rise;
    logic [1:0]  w_ld_fall;
    logic [3:0]  w_we_fall;
    logic [3:0]  w_ck_rise;
    logic [3:0]  w_wr_side;
    logic [3:0]  w_load;
    logic [3:0]  w_rd_en;
    lb_entry_t   w_wr_data [4];
    lb_entry_t   w_rd_data [4];
    logic [7:0]  w_addr [4];
    lb_entry_t   w_spr_d;
    logic [15:0] w_pa_d;
    logic        w_unused;

    assign w_unused = ^PBUS[7:0];

    always_ff @(posedge CLK_24M or posedge RESETP) begin
        if (RESETP) begin
            r_pal_in <= 8'h00;
            r_x_in   <= 8'h00;
            r_gad    <= 4'h0;
            r_gbd    <= 4'h0;
            r_pck2_c <= 1'b0;
            r_pck2_p <= 1'b0;
            r_ld_c   <= 2'b00;
            r_ld_p   <= 2'b00;
            r_we_c   <= 4'h0;
            r_we_p   <= 4'h0;
            r_ck_c   <= 4'h0;
            r_ck_p   <= 4'h0;
            r_arm    <= 2'b00;
            r_bflip  <= 1'b0;
        end else begin
            r_pal_in <= PBUS[23:16];
            r_x_in   <= PBUS[15:8];
            r_gad    <= GAD;
            r_gbd    <= GBD;
            r_pck2_c <= PCK2;
            r_pck2_p <= r_pck2_c;
            r_ld_c   <= {LD2_, LD1_};
            r_ld_p   <= r_ld_c;
            r_we_c   <= WE;
            r_we_p   <= r_we_c;
            r_ck_c   <= CK;
            r_ck_p   <= r_ck_c;
            r_arm    <= {r_arm[0], 1'b1};
            r_bflip  <= BFLIP;
        end
    end

    // History still holds reset values on the first cycle out of reset; mask that cycle
    assign w_armed     = r_arm[1];
    assign w_pck2_rise = w_armed & r_pck2_c & ~r_pck2_p;
    assign w_ld_fall   = {2{w_armed}} & ~r_ld_c & r_ld_p;
    assign w_we_fall   = {4{w_armed}} & ~r_we_c & r_we_p;
    assign w_ck_rise   = {4{w_armed}} & r_ck_c & ~r_ck_p;

    always_ff @(posedge CLK_24M or posedge RESETP) begin
        if (RESETP) begin
            r_pal <= 8'h00;
        end else if (w_pck2_rise) begin
            r_pal <= r_pal_in;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_half
        localparam bit IsEven  = (g % 2) == 1;
        localparam bit IsPairA = g < 2;

        assign w_wr_side[g] = IsPairA ? ~r_bflip : r_bflip;
        assign w_load[g]    = IsPairA ? w_ld_fall[0] : w_ld_fall[1];
        assign w_wr_data[g] = {r_pal, IsEven ? r_gad : r_gbd};

        lb_half #(
            .DEPTH (LB_DEPTH)
        ) u_half (
            .CLK_24M     (CLK_24M),
            .RESETP      (RESETP),
            .i_load      (w_load[g]),
            .i_load_addr (r_x_in),
            .i_ck_rise   (w_ck_rise[g]),
            .i_we_fall   (w_we_fall[g]),
            .i_wr_side   (w_wr_side[g]),
            .i_wr_data   (w_wr_data[g]),
            .o_rd_en     (w_rd_en[g]),
            .o_rd_data   (w_rd_data[g]),
            .o_addr      (w_addr[g])
        );
    end

    // Even before odd when strobes coincide
    always_comb begin
        w_spr_d = r_spr;
        if (w_rd_en[IDX_EVEN_A]) begin
            w_spr_d = w_rd_data[IDX_EVEN_A];
        end else if (w_rd_en[IDX_ODD_A]) begin
            w_spr_d = w_rd_data[IDX_ODD_A];
        end else if (w_rd_en[IDX_EVEN_B]) begin
            w_spr_d = w_rd_data[IDX_EVEN_B];
        end else if (w_rd_en[IDX_ODD_B]) begin
            w_spr_d = w_rd_data[IDX_ODD_B];
        end
    end

    always_comb begin
        w_pa_d = {4'h0, r_spr};
        if (CHBL) begin
            w_pa_d = 16'h0000;
        end else if (FIXD != 4'h0) begin
            w_pa_d = {8'h00, FIX_PAL, FIXD};
        end
    end

    always_ff @(posedge CLK_24M or posedge RESETP) begin
        if (RESETP) begin
            r_spr <= '0;
            r_pa  <= 16'h0000;
        end else begin
            r_spr <= w_spr_d;
            r_pa  <= w_pa_d;
        end
    end

    assign PA = r_pa;

endmodule

// File: doc/neo_b1_linebuf.md
NEO_B1_LINEBUF -- requirements
Module: neo_b1_linebuf

Interface
REQ-001 Parameter LB_DEPTH, default 256, entries per line-buffer half (pixel pairs per line).
REQ-002 CLK_24M  in  1  system clock; all state changes on its rising edge.
REQ-003 RESETP  in  1  reset, asynchronous, active-high.
REQ-004 PBUS  in  24  P bus; [23:16] sprite palette, [15:8] sprite X pair address.
REQ-005 PCK2  in  1  palette latch strobe, active-high.
REQ-006 LD1_, LD2_  in  1 each  active-low X address load for pair A and pair B.
REQ-007 WE  in  4  active-low write enables: [0] odd A, [1] even A, [2] odd B, [3] even B.
REQ-008 CK  in  4  address-advance strobes, same bit mapping as WE.
REQ-009 BFLIP  in  1  0: pair A is the write side and B the read side; 1: the reverse.
REQ-010 GAD, GBD  in  4 each  even and odd sprite pixel colour from the serializer.
REQ-011 FIXD  in  4  fix pixel colour.
REQ-012 FIX_PAL  in  4  fix palette.
REQ-013 CHBL  in  1  horizontal blank, active-high.
REQ-014 PA  out  16  palette RAM address.

Function
REQ-015 All strobes (PCK2, LD*, WE, CK) SHALL be registered once; a rising edge of a strobe SHALL be detected as current & ~previous, and a falling edge as ~current & previous.
REQ-016 A detected PCK2 rising edge SHALL latch PBUS[23:16] into PAL_LATCH, one cycle after the edge is sampled.
REQ-017 A detected LD1_ falling edge SHALL load PBUS[15:8] into both pair A address counters (even and odd).
REQ-018 A detected LD2_ falling edge SHALL do the same for the pair B counters.
REQ-019 The four address counters SHALL be 8 bits wide; a detected CK[n] rising edge SHALL increment counter n, wrapping 255->0.
REQ-020 When a load and a CK edge occur in the same cycle, the load SHALL win.
REQ-021 On the write side, a registered-low WE[n] SHALL write {PAL_LATCH, pixel} at counter n; GAD is the even pixel and GBD the odd pixel.
REQ-022 A WE and a CK edge in the same cycle SHALL write at the pre-increment address.
REQ-023 One WE low period SHALL produce exactly one write, taken on its falling edge.
REQ-024 On the read side, each CK rising edge SHALL register the 12-bit entry at the current address into SPR_OUT, one cycle latency, before the increment.
REQ-025 Even and odd halves SHALL be presented alternately: even on CK[1]/CK[3], odd on CK[0]/CK[2].
REQ-026 PA output selection:
- FIXD != 0: PA = {8'h00, FIX_PAL, FIXD}.
- else: PA = {4'h0, SPR_OUT}.
- CHBL=1: PA = 16'h0000.
- PA SHALL be registered, one cycle after SPR_OUT.
REQ-027 A BFLIP change SHALL take effect on the next cycle; an access in flight SHALL complete on its original side.

Reset
REQ-028 RESETP SHALL clear PAL_LATCH, all counters, strobe history registers, SPR_OUT and PA to 0, asynchronously.
REQ-029 Buffer RAM SHALL NOT be reset; its content after reset is undefined.
REQ-030 Strobe edges SHALL be ignored on the first cycle after RESETP deasserts.

Configuration
REQ-031 Macro NEO_B1_LB_CLEAR_EN.
- Defined: a read-side WE low SHALL write 12'h000 at counter n (clear after read).
- Undefined: read-side WE SHALL be ignored and data persists.

Structure
REQ-032 The shared package neo_b1_pkg SHALL hold LB_DEPTH, the WE/CK bit index constants, and the 12-bit entry type.
REQ-033 One sub-module, lb_half, SHALL implement one half: counter, RAM, write and read port; it SHALL be instantiated four times.

Verification
REQ-034 PBUS=24'h5A3000, PCK2 pulse, LD1_ pulse, WE[1] low with GAD=4'h7, BFLIP then 1, CK[1] reads -> PA=16'h05A7.
REQ-035 Load 8'hFF, write odd pixel 4'h3, CK[0] edge, write 4'h4 -> entries FF=3 and 00=4 (wrap verified).
REQ-036 LD2_ falling edge and CK[2] edge in the same cycle with PBUS[15:8]=8'h10 -> counter = 8'h10.
REQ-037 FIXD=4'h2, FIX_PAL=4'h9 over a sprite pixel -> PA=16'h0092; CHBL=1 -> PA=16'h0000.
REQ-038 With NEO_B1_LB_CLEAR_EN, read address 8'h20 with WE low, then read it again -> second read gives sprite 12'h000 and PA=0 when FIXD=0.
REQ-039 Assert RESETP mid-write -> PA=0 and counters=0 immediately; first strobe after release ignored.
